// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and helpers for the RAM port arbiter
//
// Holds the host index type and the lowest-set-bit priority encoder used
// for host selection. Vectors are widened to MaxHosts before encoding so one
// function serves every legal NrHosts.
package ram_arb_pkg;

  localparam int unsigned MaxHosts = 8;
  localparam int unsigned MaxIdxW  = 3;

  // Host index at the widest supported size; the top narrows it to
  // idx_width(NrHosts) bits.
  typedef logic [MaxIdxW-1:0] host_idx_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic host_idx_t lowest_set(input logic [MaxHosts-1:0] vec);
    host_idx_t idx;
    idx = '0;
    for (int i = MaxHosts - 1; i >= 0; i--) begin
      if (vec[i]) idx = host_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arb_tag_fifo.sv
// rtl/ram_arb_tag_fifo.sv - synchronous tag FIFO recording which host owns each outstanding access
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i (accepted when not full, or full with a pop)
//   pop_i           drop the head entry (ignored when empty)
//   pop_data_o      head entry
//   full_o, empty_o occupancy flags
module ram_arb_tag_fifo
  import ram_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - fixed-priority RAM port arbiter with starvation promotion and response steering
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   host_req_i / host_gnt_o          per-host request, zero-cycle grant (one-hot or zero)
//   host_we_i/be_i/addr_i/wdata_i    per-host command fields, packed host 0 in the LSBs
//   host_rvalid_o / host_err_o       per-host response valid and error (one-hot or zero)
//   host_rdata_o                     response data, broadcast to all hosts
//   ram_req_o/gnt_i/we_o/be_o/addr_o/wdata_o   RAM command port
//   ram_rvalid_i/rdata_i/err_i       RAM response port
//   rsp_orphan_o                     sticky: a response arrived with no outstanding tag
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NrHosts     = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RspDepth    = 2,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrHosts-1:0]                 host_req_i,
  output logic [NrHosts-1:0]                 host_gnt_o,
  input  logic [NrHosts-1:0]                 host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0]   host_be_i,
  input  logic [NrHosts*AddrWidth-1:0]       host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]       host_wdata_i,
  output logic [NrHosts-1:0]                 host_rvalid_o,
  output logic [DataWidth-1:0]               host_rdata_o,
  output logic [NrHosts-1:0]                 host_err_o,
  output logic                               ram_req_o,
  input  logic                               ram_gnt_i,
  output logic                               ram_we_o,
  output logic [DataWidth/8-1:0]             ram_be_o,
  output logic [AddrWidth-1:0]               ram_addr_o,
  output logic [DataWidth-1:0]               ram_wdata_o,
  input  logic                               ram_rvalid_i,
  input  logic [DataWidth-1:0]               ram_rdata_i,
  input  logic                               ram_err_i,
  output logic                               rsp_orphan_o
);

  localparam int unsigned IdxW    = idx_width(NrHosts);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned CntW    = $clog2(StarveLimit + 1);

  logic [CntW-1:0]     cnt_q [NrHosts];
  logic [NrHosts-1:0]  starved;
  logic [IdxW-1:0]     sel;
  logic [IdxW-1:0]     rsp_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                can_issue;
  logic                grant;
  logic                orphan_q;

  // A host that has waited StarveLimit cycles outranks plain priority;
  // among several starved hosts the lowest index goes first.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NrHosts; i++) begin
      starved[i] = host_req_i[i] & (cnt_q[i] == CntW'(StarveLimit));
    end
  end

  assign sel = (|starved) ? IdxW'(lowest_set(MaxHosts'(starved)))
                          : IdxW'(lowest_set(MaxHosts'(host_req_i)));

  assign fifo_pop   = ram_rvalid_i & ~fifo_empty;
  assign can_issue  = ~fifo_full | fifo_pop;
  assign ram_req_o  = (|host_req_i) & can_issue;
  assign grant      = ram_req_o & ram_gnt_i;
  assign host_gnt_o = grant ? (NrHosts'(1) << sel) : '0;

  // Command fields follow the selected host; idle cycles drive zero.
  always_comb begin
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NrHosts; i++) begin
      if (ram_req_o && (sel == IdxW'(i))) begin
        ram_we_o    = host_we_i[i];
        ram_be_o    = host_be_i[i*BeWidth +: BeWidth];
        ram_addr_o  = host_addr_i[i*AddrWidth +: AddrWidth];
        ram_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  ram_arb_tag_fifo #(
    .Depth (RspDepth),
    .Width (IdxW)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (grant),
    .push_data_i (sel),
    .pop_i       (ram_rvalid_i),
    .pop_data_o  (rsp_tag),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign host_rvalid_o = fifo_pop ? (NrHosts'(1) << rsp_tag) : '0;
  assign host_err_o    = (fifo_pop & ram_err_i) ? (NrHosts'(1) << rsp_tag) : '0;
  assign host_rdata_o  = ram_rdata_i;
  assign rsp_orphan_o  = orphan_q;

  // Counters keep running while the FIFO blocks issue, so waiting behind a
  // full FIFO still earns promotion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrHosts; i++) cnt_q[i] <= '0;
      orphan_q <= 1'b0;
    end else begin
      for (int i = 0; i < NrHosts; i++) begin
        if (host_req_i[i] && !host_gnt_o[i]) begin
          if (cnt_q[i] != CntW'(StarveLimit)) cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else begin
          cnt_q[i] <= '0;
        end
      end
      if (ram_rvalid_i && fifo_empty) orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int NH = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int RD = 2;
  localparam int SL = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NH-1:0]     host_req = '0;
  logic [NH-1:0]     host_we = '0;
  logic [NH*BW-1:0]  host_be = '0;
  logic [NH*AW-1:0]  host_addr = '0;
  logic [NH*DW-1:0]  host_wdata = '0;
  logic [NH-1:0]     host_gnt;
  logic [NH-1:0]     host_rvalid;
  logic [NH-1:0]     host_err;
  logic [DW-1:0]     host_rdata;
  logic              ram_req;
  logic              ram_gnt = 1'b1;
  logic              ram_we;
  logic [BW-1:0]     ram_be;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_rvalid = 1'b0;
  logic [DW-1:0]     ram_rdata = '0;
  logic              ram_err = 1'b0;
  logic              rsp_orphan;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NrHosts(NH), .AddrWidth(AW), .DataWidth(DW), .RspDepth(RD), .StarveLimit(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_we_i(host_we),
    .host_be_i(host_be), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .ram_req_o(ram_req), .ram_gnt_i(ram_gnt), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid),
    .ram_rdata_i(ram_rdata), .ram_err_i(ram_err), .rsp_orphan_o(rsp_orphan)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: outstanding owners in issue order, wait counts.
  int            tagq[$];
  int            cnt[NH];
  bit            orphan_m = 1'b0;
  logic [NH-1:0] gnt_seen = '0;

  // RAM responder: due cycle of each accepted access, in order.
  int due_q[$];
  int cyc = 0;
  bit auto_host = 1'b0;
  bit auto_ram = 1'b0;
  bit hold = 1'b0;
  bit rand_gnt = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int prob[NH] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int            sel;
    bit            pop;
    bit            can;
    bit            e_req;
    logic [NH-1:0] e_gnt;
    logic [NH-1:0] e_rv;
    logic [NH-1:0] e_err;
    if (!rst_n) begin
      tagq.delete();
      for (int i = 0; i < NH; i++) cnt[i] = 0;
      orphan_m = 1'b0;
      gnt_seen = '0;
    end else begin
      sel = -1;
      for (int i = 0; i < NH; i++) if (host_req[i] && cnt[i] == SL && sel < 0) sel = i;
      if (sel < 0) for (int i = 0; i < NH; i++) if (host_req[i] && sel < 0) sel = i;
      pop   = ram_rvalid && (tagq.size() > 0);
      can   = (tagq.size() < RD) || pop;
      e_req = (sel >= 0) && can;
      e_gnt = '0;
      if (e_req && ram_gnt) e_gnt[sel] = 1'b1;
      e_rv  = '0;
      e_err = '0;
      if (pop) begin
        e_rv[tagq[0]]  = 1'b1;
        e_err[tagq[0]] = ram_err;
      end
      check("ram_req", 64'(ram_req), 64'(e_req));
      check("host_gnt", 64'(host_gnt), 64'(e_gnt));
      check("host_rvalid", 64'(host_rvalid), 64'(e_rv));
      check("host_err", 64'(host_err & host_rvalid), 64'(e_err));
      check("host_rdata", 64'(host_rdata), 64'(ram_rdata));
      check("rsp_orphan", 64'(rsp_orphan), 64'(orphan_m));
      if (e_req) begin
        check("ram_we", 64'(ram_we), 64'(host_we[sel]));
        check("ram_be", 64'(ram_be), 64'(host_be[sel*BW +: BW]));
        check("ram_addr", 64'(ram_addr), 64'(host_addr[sel*AW +: AW]));
        check("ram_wdata", 64'(ram_wdata), 64'(host_wdata[sel*DW +: DW]));
      end
      if (ram_rvalid && tagq.size() == 0) orphan_m = 1'b1;
      if (pop) void'(tagq.pop_front());
      if (e_gnt != '0) tagq.push_back(sel);
      for (int i = 0; i < NH; i++)
        cnt[i] = (host_req[i] && !e_gnt[i]) ? ((cnt[i] < SL) ? cnt[i] + 1 : SL) : 0;
      gnt_seen = e_gnt;
      if (e_gnt != '0 && auto_ram) due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_host) begin
      for (int i = 0; i < NH; i++) begin
        if (gnt_seen[i]) host_req[i] = 1'b0;
        if (!host_req[i] && int'($urandom_range(99, 0)) < prob[i]) begin
          host_req[i]             = 1'b1;
          host_we[i]              = 1'($urandom_range(1, 0));
          host_be[i*BW +: BW]     = BW'($urandom);
          host_addr[i*AW +: AW]   = $urandom;
          host_wdata[i*DW +: DW]  = $urandom;
        end
      end
    end
    if (rand_gnt) ram_gnt = ($urandom_range(9, 0) != 0);
    if (auto_ram) begin
      ram_rvalid = 1'b0;
      ram_err    = 1'b0;
      ram_rdata  = $urandom;
      if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        ram_rvalid = 1'b1;
        ram_err    = ($urandom_range(3, 0) == 0);
      end
    end
  endtask

  task automatic set_host(input int i, input bit req, input bit we, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    host_req[i]            = req;
    host_we[i]             = we;
    host_be[i*BW +: BW]    = be;
    host_addr[i*AW +: AW]  = addr;
    host_wdata[i*DW +: DW] = wd;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_gnt", 64'(host_gnt), 64'd0);
    check("reset_req", 64'(ram_req), 64'd0);
    check("reset_rvalid", 64'(host_rvalid), 64'd0);
    check("reset_orphan", 64'(rsp_orphan), 64'd0);
    step();
    rst_n = 1'b1;

    // Single read from host 1.
    step();
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h0010_0010, 32'h0);
    @(negedge clk);
    check("t1_gnt", 64'(host_gnt), 64'h2);
    check("t1_addr", 64'(ram_addr), 64'h0010_0010);
    step();
    set_host(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_rvalid", 64'(host_rvalid), 64'h2);
    check("t1_rdata", 64'(host_rdata), 64'hDEAD_BEEF);
    step();
    ram_rvalid = 1'b0;

    // Both hosts continuously requesting: host 1 wins every ninth cycle.
    auto_host = 1'b1; auto_ram = 1'b1; lat_min = 1; lat_max = 1; prob = '{100, 100};
    step();
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      check($sformatf("t2_starve_k%0d", k), 64'(host_gnt), (k % 9 == 8) ? 64'h2 : 64'h1);
      step();
    end
    prob = '{0, 0};
    repeat (6) step();

    // Back-to-back reads with 2-cycle latency keep the FIFO full yet never stall.
    lat_min = 2; lat_max = 2; prob = '{100, 0};
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t3_b2b_k%0d", k), 64'(host_gnt), 64'h1);
      step();
    end
    prob = '{0, 0};
    repeat (6) step();

    // Responses held off: after two grants issue stops until the first rvalid.
    lat_min = 1; lat_max = 1; prob = '{100, 0};
    step();
    @(negedge clk);
    check("t4_gnt_c0", 64'(host_gnt), 64'h1);
    hold = 1'b1;
    step();
    @(negedge clk);
    check("t4_gnt_c1", 64'(host_gnt), 64'h1);
    for (int k = 2; k < 4; k++) begin
      step();
      @(negedge clk);
      check($sformatf("t4_stall_req_c%0d", k), 64'(ram_req), 64'd0);
      check($sformatf("t4_stall_gnt_c%0d", k), 64'(host_gnt), 64'd0);
    end
    hold = 1'b0;
    step();
    @(negedge clk);
    check("t4_resume_gnt", 64'(host_gnt), 64'h1);
    check("t4_resume_rvalid", 64'(host_rvalid), 64'h1);
    prob = '{0, 0};
    repeat (8) step();

    // Write from host 0 then read from host 1, error on the second response.
    auto_host = 1'b0; auto_ram = 1'b0;
    due_q.delete();
    step();
    host_req = '0; ram_rvalid = 1'b0; ram_err = 1'b0;
    set_host(0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'h1234_5678);
    @(negedge clk);
    check("t5_wr_gnt", 64'(host_gnt), 64'h1);
    check("t5_wr_be", 64'(ram_be), 64'h3);
    check("t5_wr_we", 64'(ram_we), 64'h1);
    step();
    set_host(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    ram_rvalid = 1'b1; ram_err = 1'b0;
    @(negedge clk);
    check("t5_rsp1_rvalid", 64'(host_rvalid), 64'h1);
    check("t5_rsp1_err", 64'(host_err), 64'h0);
    check("t5_rd_gnt", 64'(host_gnt), 64'h2);
    step();
    set_host(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ram_rvalid = 1'b1; ram_err = 1'b1;
    @(negedge clk);
    check("t5_rsp2_rvalid", 64'(host_rvalid), 64'h2);
    check("t5_rsp2_err", 64'(host_err), 64'h2);
    step();
    ram_rvalid = 1'b0; ram_err = 1'b0;

    // Reset with one access outstanding; the late response is an orphan.
    step();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    check("t6_gnt", 64'(host_gnt), 64'h1);
    step();
    set_host(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ram_rvalid = 1'b1;
    @(negedge clk);
    check("t6_orphan_rvalid", 64'(host_rvalid), 64'h0);
    step();
    ram_rvalid = 1'b0;
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    @(negedge clk);
    check("t6_orphan_flag", 64'(rsp_orphan), 64'h1);
    check("t6_next_gnt", 64'(host_gnt), 64'h2);
    step();
    set_host(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ram_rvalid = 1'b1;
    @(negedge clk);
    check("t6_next_rvalid", 64'(host_rvalid), 64'h2);
    step();
    ram_rvalid = 1'b0;

    // Randomised traffic: variable latency, back-pressure and held responses.
    auto_host = 1'b1; auto_ram = 1'b1; rand_gnt = 1'b1;
    lat_min = 1; lat_max = 3;
    prob = '{50, 50};
    for (int k = 0; k < 3000; k++) begin
      hold = ($urandom_range(4, 0) == 0);
      step();
    end
    prob = '{90, 90};
    for (int k = 0; k < 1000; k++) begin
      hold = ($urandom_range(4, 0) == 0);
      step();
    end
    prob = '{0, 0}; hold = 1'b0; rand_gnt = 1'b0; ram_gnt = 1'b1;
    repeat (30) step();
    @(negedge clk);
    check("drain_idle_req", 64'(ram_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
